time_keeper: RTL and testbench

//  Timekeeping core of the digital clock. Sits between button_controller, whose

---
 rtl/time_keeper_pkg.sv | 43 ++++
 rtl/time_keeper_bcd_mod_counter.sv | 32 +++
 rtl/time_keeper.sv | 167 ++++++++++++++++
 tb/tb_time_keeper.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_keeper_pkg.sv
// Shared encodings and BCD helpers for the time_keeper core.
package time_keeper_pkg;

  typedef enum logic [1:0] {
    MODE_RUN         = 2'b00,
    MODE_SET_TIME    = 2'b01,
    MODE_SET_ALARM   = 2'b10,
    MODE_RUN_NOALARM = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    AL_IDLE   = 2'b00,
    AL_RING   = 2'b01,
    AL_SNOOZE = 2'b10
  } al_state_e;

  localparam logic       FLD_HOUR     = 1'b0;
  localparam logic       FLD_MIN      = 1'b1;
  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
  localparam logic [7:0] BCD_MIN_MAX  = 8'h59;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // HH:MM + add minutes, wrapping through midnight; result is {hour, min} in BCD.
  function automatic logic [15:0] snooze_target(input logic [7:0] h, input logic [7:0] m,
                                                input int add);
    int hi, mi;
    hi = int'(h[7:4]) * 10 + int'(h[3:0]);
    mi = int'(m[7:4]) * 10 + int'(m[3:0]) + add;
    if (mi >= 60) begin
      mi = mi - 60;
      hi = (hi == 23) ? 0 : hi + 1;
    end
    return {to_bcd(hi), to_bcd(mi)};
  endfunction

endpackage

// File: rtl/time_keeper_bcd_mod_counter.sv
// Two-digit BCD register with clear/load/increment; wraps to 00 after MAX.
module bcd_mod_counter import time_keeper_pkg::*; #(
  parameter logic [7:0] MAX = BCD_MIN_MAX
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] ld_val,
  output logic [7:0] q,
  output logic       wrap
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)       q_d = 8'h00;
    else if (load) q_d = ld_val;
    else if (inc)  q_d = (q_q == MAX) ? 8'h00 : bcd_inc(q_q);
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) q_q <= 8'h00;
    else      q_q <= q_d;
  end

  assign q    = q_q;
  assign wrap = inc && !clr && !load && (q_q == MAX);

endmodule

// File: rtl/time_keeper.sv
// Clock core: HH:MM:SS timebase, time/alarm editors and alarm ring timer.
// Define TK_SNOOZE_EN to add the SNOOZE state and its target registers.
module time_keeper import time_keeper_pkg::*; #(
  parameter int CLK_FREQ       = 20000,
  parameter int ALARM_RING_SEC = 30,
  parameter int SNOOZE_MIN     = 5
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [1:0] vButton,
  input  logic [1:0] clk_mode,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] al_hour_bcd,
  output logic [7:0] al_min_bcd,
  output logic       field_sel,
  output logic       sec_tick,
  output logic       alarm_on
);

  localparam int            PW        = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_FREQ - 1);
  localparam logic [7:0]    RING_INIT = 8'(ALARM_RING_SEC);

  if (CLK_FREQ < 2 || ALARM_RING_SEC < 1 || ALARM_RING_SEC > 255 ||
      SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_param_chk
    $error("time_keeper: parameter out of range");
  end

  mode_e         mode_in, mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          fs_q, fs_d, tick_q;
  logic          mode_chg, enter_st, set_t, set_a, tick_now;
  logic          sec_wrap, min_wrap;
  logic          unused_hour_wrap, unused_al_min_wrap, unused_al_hour_wrap;

  assign mode_in  = mode_e'(clk_mode);
  assign mode_chg = (mode_in != mode_q);
  assign enter_st = mode_chg && (mode_in == MODE_SET_TIME);
  // Edits are ignored in the cycle the mode changes; field_sel is being reset then.
  assign set_t    = !mode_chg && (mode_in == MODE_SET_TIME);
  assign set_a    = !mode_chg && (mode_in == MODE_SET_ALARM);
  assign tick_now = (presc_q == PRE_MAX) && (mode_in != MODE_SET_TIME);

  always_comb begin
    mode_d  = mode_in;
    presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
    if (enter_st) presc_d = '0;
    fs_d = fs_q;
    if (mode_chg)                           fs_d = FLD_HOUR;
    else if ((set_t || set_a) && vButton[1]) fs_d = ~fs_q;
  end

  // Hour carry only from the seconds chain, so editing minutes never bumps hours.
  bcd_mod_counter #(.MAX(BCD_MIN_MAX)) u_sec (
    .mclk(mclk), .rst(rst), .inc(tick_now), .clr(enter_st), .load(1'b0), .ld_val(8'h00),
    .q(sec_bcd), .wrap(sec_wrap));
  bcd_mod_counter #(.MAX(BCD_MIN_MAX)) u_min (
    .mclk(mclk), .rst(rst), .inc(sec_wrap || (set_t && vButton[0] && fs_q == FLD_MIN)),
    .clr(1'b0), .load(1'b0), .ld_val(8'h00), .q(min_bcd), .wrap(min_wrap));
  bcd_mod_counter #(.MAX(BCD_HOUR_MAX)) u_hour (
    .mclk(mclk), .rst(rst),
    .inc((sec_wrap && min_wrap) || (set_t && vButton[0] && fs_q == FLD_HOUR)),
    .clr(1'b0), .load(1'b0), .ld_val(8'h00), .q(hour_bcd), .wrap(unused_hour_wrap));
  bcd_mod_counter #(.MAX(BCD_MIN_MAX)) u_al_min (
    .mclk(mclk), .rst(rst), .inc(set_a && vButton[0] && fs_q == FLD_MIN),
    .clr(1'b0), .load(1'b0), .ld_val(8'h00), .q(al_min_bcd), .wrap(unused_al_min_wrap));
  bcd_mod_counter #(.MAX(BCD_HOUR_MAX)) u_al_hour (
    .mclk(mclk), .rst(rst), .inc(set_a && vButton[0] && fs_q == FLD_HOUR),
    .clr(1'b0), .load(1'b0), .ld_val(8'h00), .q(al_hour_bcd), .wrap(unused_al_hour_wrap));

  al_state_e  st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic       at_mark, silence;
`ifdef TK_SNOOZE_EN
  logic [7:0] tgt_h_q, tgt_h_d, tgt_m_q, tgt_m_d;
`endif

  // tick_q marks the cycle in which the time registers just advanced.
  assign at_mark = tick_q && (sec_bcd == 8'h00);
  assign silence = (mode_in != MODE_RUN) || vButton[1];

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
`ifdef TK_SNOOZE_EN
    tgt_h_d = tgt_h_q;
    tgt_m_d = tgt_m_q;
`endif
    case (st_q)
      AL_IDLE: begin
        if (mode_in == MODE_RUN && at_mark &&
            hour_bcd == al_hour_bcd && min_bcd == al_min_bcd) begin
          st_d  = AL_RING;
          cnt_d = RING_INIT;
        end
      end
      AL_RING: begin
        if (silence) begin
          st_d  = AL_IDLE;
          cnt_d = '0;
        end else if (vButton[0]) begin
`ifdef TK_SNOOZE_EN
          st_d               = AL_SNOOZE;
          {tgt_h_d, tgt_m_d} = snooze_target(hour_bcd, min_bcd, SNOOZE_MIN);
`else
          st_d = AL_IDLE;
`endif
          cnt_d = '0;
        end else if (tick_q) begin
          if (cnt_q <= 8'd1) begin
            st_d  = AL_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
`ifdef TK_SNOOZE_EN
      AL_SNOOZE: begin
        if (silence) begin
          st_d = AL_IDLE;
        end else if (at_mark && hour_bcd == tgt_h_q && min_bcd == tgt_m_q) begin
          st_d  = AL_RING;
          cnt_d = RING_INIT;
        end
      end
`endif
      default: begin
        st_d  = AL_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_RUN;
      presc_q <= '0;
      fs_q    <= FLD_HOUR;
      tick_q  <= 1'b0;
      st_q    <= AL_IDLE;
      cnt_q   <= '0;
`ifdef TK_SNOOZE_EN
      tgt_h_q <= 8'h00;
      tgt_m_q <= 8'h00;
`endif
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      fs_q    <= fs_d;
      tick_q  <= tick_now;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
`ifdef TK_SNOOZE_EN
      tgt_h_q <= tgt_h_d;
      tgt_m_q <= tgt_m_d;
`endif
    end
  end

  assign field_sel = fs_q;
  assign sec_tick  = tick_q;
  assign alarm_on  = (st_q == AL_RING);

endmodule

// File: tb/tb_time_keeper.sv
// Randomized + directed bench for time_keeper against a seconds-of-day reference model.
module tb_time_keeper;

  localparam int F  = 4;
  localparam int RS = 3;
  localparam int SM = 5;

  logic       mclk = 1'b0;
  logic       rst;
  logic [1:0] vButton, clk_mode;
  logic [7:0] hour_bcd, min_bcd, sec_bcd, al_hour_bcd, al_min_bcd;
  logic       field_sel, sec_tick, alarm_on;

  always #5 mclk = ~mclk;

  time_keeper #(.CLK_FREQ(F), .ALARM_RING_SEC(RS), .SNOOZE_MIN(SM)) dut (
    .mclk(mclk), .rst(rst), .vButton(vButton), .clk_mode(clk_mode),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .al_hour_bcd(al_hour_bcd), .al_min_bcd(al_min_bcd),
    .field_sel(field_sel), .sec_tick(sec_tick), .alarm_on(alarm_on));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: time as seconds of day, alarm as hour/min, ring state 0/1/2.
  int         m_presc, m_tod, m_alh, m_alm, m_fs, m_tick, m_ast, m_cnt, m_tgt;
  logic [1:0] m_pm;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic m_reset();
    m_presc = 0; m_tod = 0; m_alh = 0; m_alm = 0; m_fs = 0;
    m_tick = 0; m_ast = 0; m_cnt = 0; m_tgt = 0; m_pm = 2'b00;
  endtask

  task automatic m_upd(input logic [1:0] m, input logic [1:0] vb);
    bit chg;
    bit ntick, mark;
    int h, mi, s, hm;
    chg   = (m != m_pm);
    h     = m_tod / 3600;
    mi    = (m_tod / 60) % 60;
    s     = m_tod % 60;
    hm    = m_tod / 60;
    mark  = (m_tick == 1) && (s == 0);
    ntick = (m_presc == F - 1) && (m != 2'b01);
    case (m_ast)
      0: if (m == 2'b00 && mark && hm == m_alh * 60 + m_alm) begin m_ast = 1; m_cnt = RS; end
      1: begin
        if (m != 2'b00 || vb[1]) m_ast = 0;
        else if (vb[0]) begin
`ifdef TK_SNOOZE_EN
          m_ast = 2;
          m_tgt = (hm + SM) % 1440;
`else
          m_ast = 0;
`endif
        end else if (m_tick == 1) begin
          m_cnt--;
          if (m_cnt == 0) m_ast = 0;
        end
      end
      2: begin
        if (m != 2'b00 || vb[1]) m_ast = 0;
        else if (mark && hm == m_tgt) begin m_ast = 1; m_cnt = RS; end
      end
      default: m_ast = 0;
    endcase
    if (ntick) m_tod = (m_tod + 1) % 86400;
    else begin
      if (m == 2'b01 && chg) s = 0;
      if (m == 2'b01 && !chg && vb[0]) begin
        if (m_fs == 0) h = (h + 1) % 24;
        else           mi = (mi + 1) % 60;
      end
      m_tod = h * 3600 + mi * 60 + s;
    end
    if (m == 2'b10 && !chg && vb[0]) begin
      if (m_fs == 0) m_alh = (m_alh + 1) % 24;
      else           m_alm = (m_alm + 1) % 60;
    end
    m_presc = (m == 2'b01 && chg) ? 0 : (m_presc + 1) % F;
    if (chg) m_fs = 0;
    else if ((m == 2'b01 || m == 2'b10) && vb[1]) m_fs = 1 - m_fs;
    m_tick = ntick ? 1 : 0;
    m_pm   = m;
  endtask

  task automatic compare_all();
    chk("hour",      hour_bcd,    bcd(m_tod / 3600));
    chk("min",       min_bcd,     bcd((m_tod / 60) % 60));
    chk("sec",       sec_bcd,     bcd(m_tod % 60));
    chk("al_hour",   al_hour_bcd, bcd(m_alh));
    chk("al_min",    al_min_bcd,  bcd(m_alm));
    chk("field_sel", field_sel,   m_fs);
    chk("sec_tick",  sec_tick,    m_tick);
    chk("alarm_on",  alarm_on,    m_ast == 1);
  endtask

  task automatic step(input logic [1:0] m, input logic [1:0] vb);
    clk_mode = m;
    vButton  = vb;
    @(posedge mclk);
    m_upd(m, vb);
    #1 compare_all();
  endtask

  task automatic set_time(input int h, input int mi);
    step(2'b00, 2'b00);
    step(2'b01, 2'b00);
    repeat ((h - m_tod / 3600 + 24) % 24) step(2'b01, 2'b01);
    step(2'b01, 2'b10);
    repeat ((mi - (m_tod / 60) % 60 + 60) % 60) step(2'b01, 2'b01);
    step(2'b00, 2'b00);
  endtask

  task automatic set_alarm(input int h, input int mi);
    step(2'b00, 2'b00);
    step(2'b10, 2'b00);
    repeat ((h - m_alh + 24) % 24) step(2'b10, 2'b01);
    step(2'b10, 2'b10);
    repeat ((mi - m_alm + 60) % 60) step(2'b10, 2'b01);
    step(2'b00, 2'b00);
  endtask

  task automatic wait_alarm(input logic [1:0] m, input logic exp, input int budget,
                            input string tag);
    int n;
    n = 0;
    while (alarm_on !== exp && n < budget) begin
      step(m, 2'b00);
      n++;
    end
    chk(tag, alarm_on, exp);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, n, h0, mi0;
    logic [1:0] rm, vb;
    rst = 1'b0; clk_mode = 2'b00; vButton = 2'b00;
    m_reset();
    #12 compare_all();
    @(negedge mclk) rst = 1'b1;

    // Roll over midnight and measure the tick period.
    set_time(23, 59);
    n = 0;
    while (m_tod != 86398 && n < 400) begin step(2'b00, 2'b00); n++; end
    chk("reach_235958", sec_bcd, 8'h58);
    c1 = -1; c2 = -1; n = 0;
    while (c2 < 0 && n < 20) begin
      step(2'b00, 2'b00);
      n++;
      if (sec_tick === 1'b1) begin if (c1 < 0) c1 = n; else c2 = n; end
    end
    chk("midnight_hour", hour_bcd, 8'h00);
    chk("midnight_min",  min_bcd,  8'h00);
    chk("midnight_sec",  sec_bcd,  8'h00);
    chk("tick_period",   c2 - c1,  F);

    // Field editing: no carry between hour and minute.
    step(2'b01, 2'b00);
    repeat ((23 - m_tod / 3600 + 24) % 24) step(2'b01, 2'b01);
    mi0 = (m_tod / 60) % 60;
    step(2'b01, 2'b01);
    chk("edit_hr_wrap", hour_bcd, 8'h00);
    chk("edit_hr_min",  min_bcd,  bcd(mi0));
    step(2'b01, 2'b10);
    repeat ((59 - (m_tod / 60) % 60 + 60) % 60) step(2'b01, 2'b01);
    h0 = m_tod / 3600;
    step(2'b01, 2'b01);
    chk("edit_min_wrap", min_bcd,  8'h00);
    chk("edit_min_hr",   hour_bcd, bcd(h0));

    // Simultaneous strobes: increment old field then toggle.
    step(2'b00, 2'b00);
    step(2'b01, 2'b00);
    repeat ((5 - m_tod / 3600 + 24) % 24) step(2'b01, 2'b01);
    step(2'b01, 2'b11);
    chk("both_hour", hour_bcd,  8'h06);
    chk("both_fs",   field_sel, 1'b1);

    // Alarm ring and timeout.
    set_alarm(7, 30);
    set_time(7, 29);
    wait_alarm(2'b00, 1'b1, 61 * F + 8, "ring_0730");
    chk("ring_hour", hour_bcd, 8'h07);
    chk("ring_min",  min_bcd,  8'h30);
    wait_alarm(2'b00, 1'b0, (RS + 1) * F + 4, "ring_timeout");

    // Disarmed run never rings.
    set_time(7, 29);
    repeat (70 * F) step(2'b11, 2'b00);
    chk("noarm", alarm_on, 1'b0);

    // Silencing paths.
    set_time(7, 29);
    wait_alarm(2'b00, 1'b1, 61 * F + 8, "ring_a");
    step(2'b00, 2'b10);
    chk("silence_vb1", alarm_on, 1'b0);
    set_time(7, 29);
    wait_alarm(2'b00, 1'b1, 61 * F + 8, "ring_b");
    step(2'b01, 2'b00);
    chk("silence_mode", alarm_on, 1'b0);
    set_time(7, 29);
    wait_alarm(2'b00, 1'b1, 61 * F + 8, "ring_c");
    rst = 1'b0;
    #1 chk("rst_async", alarm_on, 1'b0);
    m_reset();
    compare_all();
    @(negedge mclk) rst = 1'b1;

    set_alarm(7, 30);
    set_time(7, 29);
    wait_alarm(2'b00, 1'b1, 61 * F + 8, "ring_d");
    step(2'b00, 2'b01);
    chk("vb0_in_ring", alarm_on, 1'b0);
`ifdef TK_SNOOZE_EN
    wait_alarm(2'b00, 1'b1, (SM * 60 + 5) * F, "resnooze_0735");
    chk("snz_hour", hour_bcd, 8'h07);
    chk("snz_min",  min_bcd,  8'h35);
    chk("snz_sec",  sec_bcd,  8'h00);
    step(2'b00, 2'b10);
    set_alarm(23, 58);
    set_time(23, 57);
    wait_alarm(2'b00, 1'b1, 61 * F + 8, "ring_2358");
    step(2'b00, 2'b01);
    chk("snz_off", alarm_on, 1'b0);
    wait_alarm(2'b00, 1'b1, (SM * 60 + 5) * F, "resnooze_0003");
    chk("snz_wrap_hour", hour_bcd, 8'h00);
    chk("snz_wrap_min",  min_bcd,  8'h03);
    step(2'b00, 2'b10);
`endif

    // Random mode switching and strobes.
    set_alarm((m_tod / 3600 + (((m_tod / 60) % 60 == 59) ? 1 : 0)) % 24,
              ((m_tod / 60) % 60 + 1) % 60);
    rm = 2'b00;
    repeat (2000) begin
      if ($urandom_range(0, 39) == 0) rm = 2'($urandom_range(0, 3));
      vb = {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0};
      step(rm, vb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
